// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with guard interval and frame-aligned double buffering.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading-zero digits above digit 0.
module disp_scan_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GUARD    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [VAL_W-1:0]  disp_val_q, disp_val_d;
    logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [VAL_W-1:0]  shd_val_q, shd_val_d;
    logic [DIGITS-1:0] shd_dp_q, shd_dp_d;
    logic              pending_q, pending_d;
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frame_tick_q, frame_tick_d;

    logic              slot_end_c;
    logic              swap_c;
    logic              lit_c;
    logic [3:0]        cur_nib_c;
    logic              cur_dp_c;
    logic              cur_lzb_c;
    logic [DIGITS-1:0] lzb_c;

    // Standard gfedcba decode, active-high; inverted at the pins.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Slot/digit sequencing and the frame-aligned display buffer swap.
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        shd_val_d    = shd_val_q;
        shd_dp_d     = shd_dp_q;
        pending_d    = pending_q;

        slot_end_c   = (cnt_q == CNT_LAST);
        swap_c       = slot_end_c && (idx_q == IDX_LAST);
        frame_tick_d = swap_c;

        if (slot_end_c) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        if (swap_c) begin
            // A load landing on the swap goes straight to the display; any older shadow is dropped.
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_mask;
            end else if (pending_q) begin
                disp_val_d = shd_val_q;
                disp_dp_d  = shd_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shd_val_d = value;
            shd_dp_d  = dp_mask;
            pending_d = 1'b1;
        end
    end

    // Per-digit leading-zero suppression flags.
    always_comb begin
        lzb_c = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic all_zero;
            all_zero = 1'b1;
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                all_zero = all_zero && (disp_val_q[i*4 +: 4] == 4'h0);
                lzb_c[i] = all_zero;
            end
        end
`endif
    end

    // Registered pin drive for the digit selected this cycle.
    always_comb begin
        cur_nib_c = 4'h0;
        cur_dp_c  = 1'b0;
        cur_lzb_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib_c = disp_val_q[i*4 +: 4];
                cur_dp_c  = disp_dp_q[i];
                cur_lzb_c = lzb_c[i];
            end
        end

        lit_c = (cnt_q >= CNT_GUARD) && !blank;

        seg_d = 8'hFF;
        if (lit_c && !cur_lzb_c) begin
            seg_d = {~cur_dp_c, ~hex_glyph(cur_nib_c)};
        end

        an_d = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            an_d[i] = !(lit_c && (idx_q == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            shd_val_q    <= '0;
            shd_dp_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 8'hFF;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            shd_val_q    <= shd_val_d;
            shd_dp_q     <= shd_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a cycle-count reference model queues expected pin states, a monitor compares.
module tb_disp_scan_ctrl;

    localparam int D  = 4;
    localparam int SD = 8;
    localparam int G  = 2;
    localparam int FR = D * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic        blank = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        pending;
    logic        frame_tick;

    disp_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .GUARD(G)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_mask(dp_mask),
        .blank(blank), .seg(seg), .an(an), .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] an;
        logic       pend;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Reference state: n = edges since reset release; buffers as whole hex words.
    int          n = 0;
    logic [15:0] m_disp = '0;
    logic [3:0]  m_disp_dp = '0;
    logic [15:0] m_shd = '0;
    logic [3:0]  m_shd_dp = '0;
    bit          m_pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // One clock of stimulus; the expected pin state after the next rising edge is queued.
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] dm, input bit bl, input bit rst);
        exp_t e;
        int ph, slot;
        bit sw, lit, zb;
        logic [15:0] sh;
        @(negedge clk);
        load = ld; value = v; dp_mask = dm; blank = bl;
        if (rst) begin
            rst_n = 1'b0;
            n = 0; m_disp = '0; m_disp_dp = '0; m_shd = '0; m_shd_dp = '0; m_pend = 0;
            e.seg = 8'hFF; e.an = 4'hF; e.pend = 1'b0; e.ft = 1'b0;
            exp_q.push_back(e);
            return;
        end
        rst_n = 1'b1;
        ph   = n % SD;
        slot = (n / SD) % D;
        sw   = (n % FR) == FR - 1;
        lit  = (ph >= G) && !bl;
        e.seg = 8'hFF;
        e.an  = 4'hF;
        if (lit) begin
            e.an = ~(4'b0001 << slot);
            sh = m_disp >> (4 * slot);
            zb = 0;
`ifdef LEADING_ZERO_BLANK_EN
            zb = (slot > 0) && (sh == 16'h0);
`endif
            if (!zb) e.seg = {~m_disp_dp[slot], ~glyph(sh[3:0])};
        end
        if (sw) begin
            if (ld) begin m_disp = v; m_disp_dp = dm; end
            else if (m_pend) begin m_disp = m_shd; m_disp_dp = m_shd_dp; end
            m_pend = 0;
        end else if (ld) begin
            m_shd = v; m_shd_dp = dm; m_pend = 1;
        end
        e.pend = m_pend;
        e.ft   = sw;
        n++;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, '0, '0, 0, 0);
    endtask

    task automatic idle_until(input int ph);
        for (int i = 0; i < FR && (n % FR) != ph; i++) step(0, '0, '0, 0, 0);
    endtask

    // Monitor: compares every presented pin state against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("seg", 32'(seg), 32'(e.seg));
            chk("an", 32'(an), 32'(e.an));
            chk("pending", 32'(pending), 32'(e.pend));
            chk("frame_tick", 32'(frame_tick), 32'(e.ft));
        end
    end

    initial begin
        bit bl;
        logic [15:0] v;
        // Reset held, then idle frames showing zeros.
        for (int i = 0; i < 3; i++) step(0, '0, '0, 0, 1);
        idle(2 * FR + 5);

        // Mid-frame load, swapped in at the next frame.
        idle_until(10);
        step(1, 16'h12AF, 4'b0100, 0, 0);
        idle(2 * FR);

        // Two loads in one frame: last one wins.
        idle_until(3);
        step(1, 16'h1111, 4'b0000, 0, 0);
        idle_until(20);
        step(1, 16'h2222, 4'b0000, 0, 0);
        idle(2 * FR);

        // Load coinciding with the swap cycle.
        idle_until(FR - 1);
        step(1, 16'h0005, 4'b0000, 0, 0);
        idle(FR + 4);

        // Blank for 20 clocks mid-frame.
        idle_until(6);
        for (int i = 0; i < 20; i++) step(0, '0, '0, 1, 0);
        idle(FR);

        // Leading-zero pattern (suppressed only when the option is built in).
        idle_until(12);
        step(1, 16'h0030, 4'b0000, 0, 0);
        idle(2 * FR);

        // Randomized loads, values and blank runs.
        bl = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) bl = ~bl;
            v = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
            step($urandom_range(0, 9) == 0, v, 4'($urandom), bl, 0);
        end
        idle(FR);

        // Asynchronous reset mid-slot, checked before any further edge.
        idle_until(FR + 4 - FR);
        step(1, 16'hBEEF, 4'b1111, 0, 0);
        idle(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_seg", 32'(seg), 32'hFF);
        chk("async_an", 32'(an), 32'hF);
        chk("async_pending", 32'(pending), 32'h0);
        chk("async_frame_tick", 32'(frame_tick), 32'h0);
        step(0, '0, '0, 0, 1);
        step(0, '0, '0, 0, 1);
        idle(2 * FR + 3);

        @(posedge clk);
        #3;
        chk("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
